// File: rtl/vga_line_fetch_scheduler_if.sv
// rtl/vga_line_fetch_scheduler_if.sv - PPU write port and frame-buffer RAM port bundle
// master: the scheduler; slave: PPU writer plus frame-buffer RAM.
interface vga_line_fetch_scheduler_if;
   logic        ppu_req;
   logic [15:0] ppu_addr;
   logic [5:0]  ppu_data;
   logic        ppu_ack;
   logic [15:0] fb_addr;
   logic        fb_we;
   logic [5:0]  fb_wdata;
   logic [5:0]  fb_rdata;

   modport master (
      input  ppu_req, ppu_addr, ppu_data, fb_rdata,
      output ppu_ack, fb_addr, fb_we, fb_wdata
   );

   modport slave (
      output ppu_req, ppu_addr, ppu_data, fb_rdata,
      input  ppu_ack, fb_addr, fb_we, fb_wdata
   );
endinterface

// File: rtl/vga_line_fetch_scheduler.sv
// rtl/vga_line_fetch_scheduler.sv - ping-pong scanline prefetch and frame-buffer port arbiter
// Fetches each NES line one VGA line pair ahead; the PPU writes whenever no burst is reading.
module vga_line_fetch_scheduler #(
   parameter int X_OFFSET = 64,
   parameter int SRC_W    = 256,
   parameter int SRC_H    = 240,
   parameter int V_LAST   = 524
) (
   input  logic                              Clk,
   input  logic                              Reset_n,
   input  logic [9:0]                        DrawX,
   input  logic [9:0]                        DrawY,
   vga_line_fetch_scheduler_if.master        bus,
   output logic [5:0]                        pixel_index,
   output logic                              pixel_valid,
   output logic                              fetch_busy,
   output logic                              fetch_overrun
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [9:0] X_LO       = 10'(X_OFFSET);
   localparam logic [9:0] X_SPAN     = 10'(2 * SRC_W);
   localparam logic [9:0] Y_HI       = 10'(2 * SRC_H);
   localparam logic [9:0] Y_TRIG_END = 10'(2 * SRC_H - 2);
   localparam logic [9:0] Y_WRAP     = 10'(V_LAST);
   localparam logic [7:0] X_END      = 8'(SRC_W - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] line_q, line_d;
   logic       bank_q, bank_d;
   logic [7:0] x_q, x_d;
   logic       cap_valid_q, cap_valid_d;
   logic [7:0] cap_x_q, cap_x_d;
   logic       cap_bank_q, cap_bank_d;
   logic       overrun_q, overrun_d;
   logic [5:0] pix_index_q, pix_index_d;
   logic       pix_valid_q, pix_valid_d;

   logic [5:0] linebuf [0:2*SRC_W-1];

   logic       trig_even, trig_wrap, trigger, fetching, in_win;
   logic [7:0] trig_line;
   logic [9:0] dx;

   // Even VGA lines prefetch the next source line; the last frame line primes line 0.
   always_comb begin
      trig_even = (DrawX == 10'd0) && !DrawY[0] && (DrawY < Y_TRIG_END);
      trig_wrap = (DrawX == 10'd0) && (DrawY == Y_WRAP);
      trigger   = trig_even || trig_wrap;
      trig_line = trig_wrap ? 8'd0 : DrawY[8:1] + 8'd1;
   end

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      bank_d      = bank_q;
      x_d         = x_q;
      cap_valid_d = 1'b0;
      cap_x_d     = cap_x_q;
      cap_bank_d  = cap_bank_q;
      overrun_d   = overrun_q;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               line_d  = trig_line;
               bank_d  = trig_line[0];
               x_d     = 8'd0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            cap_valid_d = 1'b1;
            cap_x_d     = x_q;
            cap_bank_d  = bank_q;
            x_d         = x_q + 8'd1;
            if (x_q == X_END) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (trigger && (state_q != S_IDLE)) overrun_d = 1'b1;
   end

   // The PPU owns the port in DRAIN too: read data for the last x is already in flight.
   assign fetching     = (state_q == S_FETCH);
   assign bus.ppu_ack  = bus.ppu_req & ~fetching;
   assign bus.fb_we    = bus.ppu_ack;
   assign bus.fb_addr  = fetching ? {line_q, x_q} : bus.ppu_addr;
   assign bus.fb_wdata = bus.ppu_data;

   always_comb begin
      dx          = DrawX - X_LO;
      in_win      = (DrawX >= X_LO) && (dx < X_SPAN) && (DrawY < Y_HI);
      pix_index_d = in_win ? linebuf[{DrawY[1], dx[8:1]}] : 6'd0;
      pix_valid_d = in_win;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_IDLE;
         line_q      <= 8'd0;
         bank_q      <= 1'b0;
         x_q         <= 8'd0;
         cap_valid_q <= 1'b0;
         cap_x_q     <= 8'd0;
         cap_bank_q  <= 1'b0;
         overrun_q   <= 1'b0;
         pix_index_q <= 6'd0;
         pix_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         bank_q      <= bank_d;
         x_q         <= x_d;
         cap_valid_q <= cap_valid_d;
         cap_x_q     <= cap_x_d;
         cap_bank_q  <= cap_bank_d;
         overrun_q   <= overrun_d;
         pix_index_q <= pix_index_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (cap_valid_q) linebuf[{cap_bank_q, cap_x_q}] <= bus.fb_rdata;
   end

   assign pixel_index   = pix_index_q;
   assign pixel_valid   = pix_valid_q;
   assign fetch_busy    = (state_q != S_IDLE);
   assign fetch_overrun = overrun_q;

endmodule

// File: tb/tb_vga_line_fetch_scheduler.sv
// tb/tb_vga_line_fetch_scheduler.sv - directed self-checking bench for vga_line_fetch_scheduler
// Frame buffer word {line, x} is preloaded with (x ^ line)[5:0].
module tb_vga_line_fetch_scheduler;

   logic       clk;
   logic       rst_n;
   logic [9:0] draw_x;
   logic [9:0] draw_y;
   logic [5:0] pixel_index;
   logic       pixel_valid;
   logic       fetch_busy;
   logic       fetch_overrun;

   int n_cmp = 0;
   int n_bad = 0;

   logic [5:0] fb_mem [0:65535];

   vga_line_fetch_scheduler_if bus ();

   vga_line_fetch_scheduler dut (
      .Clk           (clk),
      .Reset_n       (rst_n),
      .DrawX         (draw_x),
      .DrawY         (draw_y),
      .bus           (bus),
      .pixel_index   (pixel_index),
      .pixel_valid   (pixel_valid),
      .fetch_busy    (fetch_busy),
      .fetch_overrun (fetch_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.fb_we) fb_mem[bus.fb_addr] <= bus.fb_wdata;
      bus.fb_rdata <= fb_mem[bus.fb_addr];
   end

   function automatic logic [5:0] exp_pix(input int line, input int x);
      return 6'((x ^ line) & 63);
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_pix(input string tag, input int y, input int xcol, input logic [5:0] e_idx, input logic e_vld);
      draw_y = 10'(y);
      draw_x = 10'(xcol);
      tick();
      chk($sformatf("%s_valid y%0d x%0d", tag, y, xcol), 16'(pixel_valid), 16'(e_vld));
      chk($sformatf("%s_index y%0d x%0d", tag, y, xcol), 16'(pixel_index), 16'(e_idx));
   endtask

   initial begin
      int ks0 [6];
      int ks6 [4];
      ks0 = '{0, 1, 37, 63, 64, 255};
      ks6 = '{0, 1, 100, 255};
      for (int a = 0; a < 65536; a++) fb_mem[a] = 6'(((a & 255) ^ (a >> 8)) & 63);

      rst_n        = 1'b0;
      draw_x       = 10'd5;
      draw_y       = 10'd5;
      bus.ppu_req  = 1'b0;
      bus.ppu_addr = 16'h0000;
      bus.ppu_data = 6'h00;
      repeat (3) tick();
      chk("rst_busy", 16'(fetch_busy), 16'h0);
      chk("rst_overrun", 16'(fetch_overrun), 16'h0);
      chk("rst_pix_index", 16'(pixel_index), 16'h0);
      chk("rst_pix_valid", 16'(pixel_valid), 16'h0);
      chk("rst_ppu_ack", 16'(bus.ppu_ack), 16'h0);
      chk("rst_fb_we", 16'(bus.fb_we), 16'h0);
      rst_n = 1'b1;
      tick();

      // frame prefetch of line 0 into bank 0
      draw_y = 10'd524;
      draw_x = 10'd0;
      tick();
      draw_x = 10'd1;
      #1;
      for (int i = 0; i < 256; i++) begin
         chk($sformatf("pre_addr %0d", i), bus.fb_addr, 16'(i));
         chk($sformatf("pre_we %0d", i), 16'(bus.fb_we), 16'h0);
         chk($sformatf("pre_busy %0d", i), 16'(fetch_busy), 16'h1);
         tick();
      end
      chk("pre_busy_drain", 16'(fetch_busy), 16'h1);
      tick();
      chk("pre_busy_done", 16'(fetch_busy), 16'h0);
      foreach (ks0[j]) chk_pix("pre_disp", 0, 64 + 2 * ks0[j] + 1, 6'(ks0[j] & 63), 1'b1);

      // steady-state fetch of line 6 with the PPU waiting
      draw_y = 10'd10;
      draw_x = 10'd0;
      tick();
      draw_x       = 10'd1;
      bus.ppu_req  = 1'b1;
      bus.ppu_addr = 16'h06FF;
      bus.ppu_data = 6'h3F;
      #1;
      for (int i = 0; i < 256; i++) begin
         chk($sformatf("ss_addr %0d", i), bus.fb_addr, 16'h0600 + 16'(i));
         chk($sformatf("ss_ack_wait %0d", i), 16'(bus.ppu_ack), 16'h0);
         tick();
      end
      chk("drain_ack", 16'(bus.ppu_ack), 16'h1);
      chk("drain_we", 16'(bus.fb_we), 16'h1);
      chk("drain_addr", bus.fb_addr, 16'h06FF);
      chk("drain_busy", 16'(fetch_busy), 16'h1);
      tick();
      bus.ppu_req = 1'b0;
      #1;
      chk("drain_write_landed", 16'(fb_mem[16'h06FF]), 16'h3F);
      chk("ss_busy_done", 16'(fetch_busy), 16'h0);
      foreach (ks6[j]) begin
         chk_pix("ss_disp12", 12, 64 + 2 * ks6[j], exp_pix(6, ks6[j]), 1'b1);
         chk_pix("ss_disp13", 13, 64 + 2 * ks6[j] + 1, exp_pix(6, ks6[j]), 1'b1);
      end

      // idle grant is immediate
      bus.ppu_req  = 1'b1;
      bus.ppu_addr = 16'h1234;
      bus.ppu_data = 6'h05;
      #1;
      chk("idle_ack", 16'(bus.ppu_ack), 16'h1);
      chk("idle_we", 16'(bus.fb_we), 16'h1);
      chk("idle_addr", bus.fb_addr, 16'h1234);
      chk("idle_wdata", 16'(bus.fb_wdata), 16'h05);
      tick();
      bus.ppu_req = 1'b0;

      // overrun: second trigger 100 cycles into a line-11 burst
      draw_y = 10'd20;
      draw_x = 10'd0;
      tick();
      draw_x = 10'd1;
      #1;
      for (int i = 0; i < 256; i++) begin
         chk($sformatf("ovr_addr %0d", i), bus.fb_addr, 16'h0B00 + 16'(i));
         if (i == 99) draw_x = 10'd0;
         if (i == 100) draw_x = 10'd1;
         tick();
      end
      chk("ovr_busy_drain", 16'(fetch_busy), 16'h1);
      tick();
      chk("ovr_busy_done", 16'(fetch_busy), 16'h0);
      chk("ovr_flag", 16'(fetch_overrun), 16'h1);
      chk_pix("ovr_disp", 22, 64 + 2 * 5, exp_pix(11, 5), 1'b1);
      chk_pix("ovr_disp", 22, 64 + 2 * 200, exp_pix(11, 200), 1'b1);
      chk("ovr_sticky", 16'(fetch_overrun), 16'h1);

      // reset mid-burst of line 13 into bank 1
      draw_y = 10'd24;
      draw_x = 10'd0;
      tick();
      draw_x = 10'd1;
      repeat (50) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 16'(fetch_busy), 16'h0);
      chk("mid_rst_overrun", 16'(fetch_overrun), 16'h0);
      chk("mid_rst_pix_index", 16'(pixel_index), 16'h0);
      chk("mid_rst_pix_valid", 16'(pixel_valid), 16'h0);
      chk("mid_rst_ppu_ack", 16'(bus.ppu_ack), 16'h0);
      chk("mid_rst_fb_we", 16'(bus.fb_we), 16'h0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", 16'(fetch_busy), 16'h0);
      chk_pix("rst_lb_written", 22, 64 + 2 * 10, exp_pix(13, 10), 1'b1);
      chk_pix("rst_lb_written", 22, 64 + 2 * 48, exp_pix(13, 48), 1'b1);
      chk_pix("rst_lb_kept", 22, 64 + 2 * 49, exp_pix(11, 49), 1'b1);
      chk_pix("rst_lb_kept", 22, 64 + 2 * 200, exp_pix(11, 200), 1'b1);

      // window edges
      chk_pix("win_x63", 0, 63, 6'd0, 1'b0);
      chk_pix("win_x64", 0, 64, exp_pix(6, 0), 1'b1);
      chk_pix("win_x575", 0, 575, exp_pix(6, 255), 1'b1);
      chk_pix("win_x576", 0, 576, 6'd0, 1'b0);
      chk_pix("win_y479", 479, 100, exp_pix(13, 18), 1'b1);
      chk_pix("win_y480", 480, 100, 6'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_line_fetch_scheduler.md
Name: vga_line_fetch_scheduler

Overview:
- Sequences NES frame-buffer reads into a ping-pong scanline buffer ahead of the 640x480 VGA scan, and shares the single-port frame-buffer RAM between the PPU writer and the line fetcher.
- Displays the 256x240 NES image 2x scaled (512x480), horizontally centred. Sits between the PPU, the frame-buffer RAM and the VGA timing counters (DrawX/DrawY).

Parameters:
- X_OFFSET, 64, first VGA column of the scaled image.
- SRC_W, 256, NES pixels per source line.
- SRC_H, 240, NES source lines.
- V_LAST, 524, last VGA line number (frame wrap).

Ports:
- Clk  in  1  pixel clock, same as the VGA timing counters.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current VGA column.
- DrawY  in  10  current VGA line.
- ppu_req  in  1  PPU write request; held until acked.
- ppu_addr  in  16  PPU write address, {line[7:0], x[7:0]}.
- ppu_data  in  6  PPU palette index.
- ppu_ack  out  1  write performed this cycle.
- fb_addr  out  16  frame-buffer address.
- fb_we  out  1  frame-buffer write enable.
- fb_wdata  out  6  frame-buffer write data.
- fb_rdata  in  6  read data, valid the cycle after a read address.
- pixel_index  out  6  palette index for the current VGA pixel.
- pixel_valid  out  1  pixel_index is inside the image window.
- fetch_busy  out  1  fetch FSM not IDLE.
- fetch_overrun  out  1  sticky: trigger arrived while busy.

Behaviour:
- Async reset (Reset_n low), with the following values:
  - FSM = IDLE; fetch_busy = 0; fetch_overrun = 0.
  - pixel_index = 0; pixel_valid = 0; ppu_ack = 0; fb_we = 0.
  - Line-buffer contents are undefined.
- Reset mid-fetch aborts the burst. No write reaches the line buffer after reset asserts.
- Triggers are sampled when DrawX == 0:
  - If DrawY[0] == 0 and DrawY < 478: fetch source line L = (DrawY>>1)+1 into bank L[0].
  - If DrawY == V_LAST: fetch line 0 into bank 0.
- FSM states:
  - IDLE: on a trigger, latch L and bank, set x = 0, go to FETCH.
  - FETCH: each cycle drive fb_addr = {L, x}, fb_we = 0, then increment x. After x = 255 is issued, go to DRAIN.
  - DRAIN: one cycle to capture the final read, then go to IDLE.
- Line-buffer capture: the cycle after each FETCH read of x, write fb_rdata to linebuf[bank][x]. A burst is 256 reads, and the FSM is busy for 257 cycles.
- Trigger while not IDLE: ignore it, set fetch_overrun = 1 (sticky until reset), and let the current burst continue.
- Arbitration:
  - The fetcher has absolute priority during FETCH. In every other state the PPU owns the port.
  - Grant is combinational: ppu_ack = ppu_req & (state != FETCH).
  - When granted: fb_we = 1, fb_addr = ppu_addr, fb_wdata = ppu_data.
  - The PPU waits at most 256 cycles per burst. A write in DRAIN does not disturb the in-flight read data.
- Display read path:
  - In window when X_OFFSET <= DrawX < X_OFFSET+512 and DrawY < 480.
  - Source x = (DrawX − X_OFFSET)>>1. Bank = (DrawY>>1)[0].
  - pixel_index and pixel_valid are registered, so latency is 1 cycle after DrawX/DrawY.
  - Outside the window: pixel_index = 0, pixel_valid = 0.
- Width rules: the X_OFFSET subtraction is 10-bit and is only used inside the window. L is 8 bits and is always < 240.
- Bank safety: display reads bank (DrawY>>1)[0] while fetch writes the other bank. Each fetch has 800 cycles before its bank is displayed.

Test Plan:
- Reset: hold Reset_n low mid-FETCH, then release. Require all outputs at reset values, FSM IDLE, and no line-buffer writes.
- Frame prefetch:
  - Preload fb[{0,x}] = x[5:0]. Drive DrawY = 524, DrawX = 0.
  - Require fb_addr to step 0x0000..0x00FF over 256 consecutive cycles, and fetch_busy to fall 257 cycles after the trigger.
  - Then at DrawY = 0, DrawX = 64+2k+1, require pixel_index = k[5:0] and pixel_valid = 1 one cycle later.
- Steady state: DrawY = 10, DrawX = 0 starts a fetch of line 6 into bank 0. Require fb_addr = 0x0600 first; lines 12/13 then display fb line 6.
- Contention:
  - ppu_req held from the trigger cycle: require ppu_ack = 0 for 256 cycles, then ppu_ack = 1 in DRAIN.
  - Check fb_we = 1 and fb_addr = ppu_addr in that cycle.
  - With no fetch active, require ppu_ack the same cycle as ppu_req.
- Overrun: force a second trigger 100 cycles into a burst. Require fetch_overrun = 1 until reset, with the burst completing unaltered (256 reads).
- Window edges: require pixel_valid = 0 at DrawX = 63, 576 and at DrawY = 480. Require pixel_valid = 1 at DrawX = 64 and 575, each checked one cycle later.
